// File: rtl/jtag_tap_os.sv
// jtag_tap_os: oversampled JTAG slave. The TAP controller and the IR/DR shift
// paths run entirely in the system clock domain. tck/tms/tdi are synchronised
// and edge-detected, so there is no tck clock tree. The instructions are IDCODE,
// NREG generic user data registers and BYPASS.
module jtag_tap_os #(
  parameter int                     IR_W     = 5,
  parameter int                     NREG     = 4,
  parameter int                     DR_W     = 32,
  parameter int                     ID_W     = 40,
  parameter int                     ID_INSTR = 0,
  parameter int                     USR_BASE = 1,
  parameter logic [NREG-1:0]        WR_MASK  = {NREG{1'b1}},
  parameter logic [NREG-1:0]        CAP_MASK = {NREG{1'b0}},
  parameter logic [NREG*DR_W-1:0]   RST_VAL  = {NREG*DR_W{1'b0}}
) (
  input  logic                   clk,
  input  logic                   hard_rst,
  input  logic                   tck,
  input  logic                   tms,
  input  logic                   tdi,
  output logic                   tdo,
  input  logic [ID_W-1:0]        id,
  input  logic [NREG*DR_W-1:0]   cap_data,
  output logic [NREG*DR_W-1:0]   upd_data,
  output logic [NREG-1:0]        upd_stb,
  output logic [NREG-1:0]        cap_stb,
  output logic [IR_W-1:0]        ir,
  output logic [3:0]             jstate
);

  // The shared DR shift register is wide enough for the larger of IDCODE and a user register
  localparam int              SR_W   = (ID_W > DR_W) ? ID_W : DR_W;
  localparam logic [IR_W-1:0] ID_IR  = IR_W'(ID_INSTR);
  localparam logic [31:0]     ID_CODE = 32'(ID_INSTR);
  localparam logic [31:0]     USR_LO = 32'(USR_BASE);
  localparam logic [31:0]     USR_HI = 32'(USR_BASE + NREG);

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PS_DR  = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PS_IR  = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_e;

  // Synchroniser and edge-detect flops
  logic tck_s1_q, tck_s1_d;
  logic tck_s_q,  tck_s_d;
  logic tck_d_q,  tck_d_d;
  logic tms_s1_q, tms_s1_d;
  logic tms_s_q,  tms_s_d;
  logic tdi_s1_q, tdi_s1_d;
  logic tdi_s_q,  tdi_s_d;
  logic [1:0] settle_cnt_q, settle_cnt_d;

  // TAP and datapath state
  tap_state_e               state_q, state_d, tap_next;
  logic [IR_W-1:0]          ir_q, ir_d;
  logic [IR_W-1:0]          ir_sr_q, ir_sr_d;
  logic [SR_W-1:0]          sreg_q, sreg_d;
  logic [NREG*DR_W-1:0]     upd_data_q, upd_data_d;
  logic [NREG-1:0]          upd_stb_q, upd_stb_d;
  logic [NREG-1:0]          cap_stb_q, cap_stb_d;
  logic                     tdo_q, tdo_d;

  // Decode and helper nets
  logic                     edge_en, rise, fall;
  logic [31:0]              ir_u;
  logic                     sel_id, sel_usr;
  logic [NREG-1:0]          usr_onehot;
  logic [SR_W-1:0]          cap_val;
  logic [SR_W-1:0]          sreg_shift;

  // Pin synchronisers plus a settle counter that keeps edges masked while the pipe refills after reset
  always_comb begin
    tck_s1_d = tck;
    tck_s_d  = tck_s1_q;
    tck_d_d  = tck_s_q;
    tms_s1_d = tms;
    tms_s_d  = tms_s1_q;
    tdi_s1_d = tdi;
    tdi_s_d  = tdi_s1_q;
    settle_cnt_d = (settle_cnt_q == 2'd3) ? 2'd3 : settle_cnt_q + 2'd1;
    edge_en = (settle_cnt_q == 2'd3);
    rise    = edge_en & tck_s_q & ~tck_d_q;
    fall    = edge_en & ~tck_s_q & tck_d_q;
  end

  // IEEE 1149.1 TAP next-state function; the state only advances on a detected tck rise
  always_comb begin
    tap_next = state_q;
    case (state_q)
      TLR:     tap_next = tms_s_q ? TLR    : RTI;
      RTI:     tap_next = tms_s_q ? SEL_DR : RTI;
      SEL_DR:  tap_next = tms_s_q ? SEL_IR : CAP_DR;
      CAP_DR:  tap_next = tms_s_q ? EX1_DR : SH_DR;
      SH_DR:   tap_next = tms_s_q ? EX1_DR : SH_DR;
      EX1_DR:  tap_next = tms_s_q ? UPD_DR : PS_DR;
      PS_DR:   tap_next = tms_s_q ? EX2_DR : PS_DR;
      EX2_DR:  tap_next = tms_s_q ? UPD_DR : SH_DR;
      UPD_DR:  tap_next = tms_s_q ? SEL_DR : RTI;
      SEL_IR:  tap_next = tms_s_q ? TLR    : CAP_IR;
      CAP_IR:  tap_next = tms_s_q ? EX1_IR : SH_IR;
      SH_IR:   tap_next = tms_s_q ? EX1_IR : SH_IR;
      EX1_IR:  tap_next = tms_s_q ? UPD_IR : PS_IR;
      PS_IR:   tap_next = tms_s_q ? EX2_IR : PS_IR;
      EX2_IR:  tap_next = tms_s_q ? UPD_IR : SH_IR;
      UPD_IR:  tap_next = tms_s_q ? SEL_DR : RTI;
      default: tap_next = TLR;
    endcase
    state_d = rise ? tap_next : state_q;
  end

  // Instruction decode: IDCODE, one of the user registers, or BYPASS for anything else
  always_comb begin
    ir_u       = 32'(ir_q);
    sel_id     = (ir_u == ID_CODE);
    sel_usr    = !sel_id && (ir_u >= USR_LO) && (ir_u < USR_HI);
    usr_onehot = '0;
    for (int k = 0; k < NREG; k++) begin
      usr_onehot[k] = sel_usr && (ir_u == USR_LO + 32'(k));
    end
  end

  // Capture source and shift-in position for whichever data register is selected
  always_comb begin
    cap_val = '0;
    if (sel_id) begin
      cap_val = SR_W'(id);
    end
    for (int k = 0; k < NREG; k++) begin
      if (usr_onehot[k]) begin
        cap_val = SR_W'(CAP_MASK[k] ? cap_data[k*DR_W +: DR_W] : upd_data_q[k*DR_W +: DR_W]);
      end
    end
    sreg_shift = sreg_q >> 1;
    if (sel_id) begin
      sreg_shift[ID_W-1] = tdi_s_q;
    end else if (sel_usr) begin
      sreg_shift[DR_W-1] = tdi_s_q;
    end else begin
      sreg_shift[0] = tdi_s_q;
    end
  end

  // State actions fire on the rise that leaves a state; tdo is refreshed on the fall
  always_comb begin
    sreg_d     = sreg_q;
    ir_sr_d    = ir_sr_q;
    ir_d       = ir_q;
    upd_data_d = upd_data_q;
    upd_stb_d  = '0;
    cap_stb_d  = '0;
    tdo_d      = tdo_q;
    if (rise) begin
      case (state_q)
        CAP_DR: begin
          sreg_d    = cap_val;
          cap_stb_d = usr_onehot;
        end
        SH_DR: begin
          sreg_d = sreg_shift;
        end
        UPD_DR: begin
          for (int k = 0; k < NREG; k++) begin
            if (usr_onehot[k] && WR_MASK[k]) begin
              upd_data_d[k*DR_W +: DR_W] = sreg_q[DR_W-1:0];
              upd_stb_d[k] = 1'b1;
            end
          end
        end
        CAP_IR: begin
          ir_sr_d = ir_q;
        end
        SH_IR: begin
          ir_sr_d = {tdi_s_q, ir_sr_q[IR_W-1:1]};
        end
        UPD_IR: begin
          ir_d = ir_sr_q;
        end
        default: begin
        end
      endcase
      if (tap_next == TLR) begin
        ir_d = ID_IR;
      end
    end
    if (fall) begin
      if (state_q == SH_IR) begin
        tdo_d = ir_sr_q[0];
      end else if (state_q == SH_DR) begin
        tdo_d = sreg_q[0];
      end else begin
        tdo_d = 1'b0;
      end
    end
  end

  // All state registers, with a synchronous active-low reset that also aborts any scan in progress
  always_ff @(posedge clk) begin
    if (!hard_rst) begin
      tck_s1_q     <= 1'b0;
      tck_s_q      <= 1'b0;
      tck_d_q      <= 1'b0;
      tms_s1_q     <= 1'b0;
      tms_s_q      <= 1'b0;
      tdi_s1_q     <= 1'b0;
      tdi_s_q      <= 1'b0;
      settle_cnt_q <= 2'd0;
      state_q      <= TLR;
      ir_q         <= ID_IR;
      ir_sr_q      <= '0;
      sreg_q       <= '0;
      upd_data_q   <= RST_VAL;
      upd_stb_q    <= '0;
      cap_stb_q    <= '0;
      tdo_q        <= 1'b0;
    end else begin
      tck_s1_q     <= tck_s1_d;
      tck_s_q      <= tck_s_d;
      tck_d_q      <= tck_d_d;
      tms_s1_q     <= tms_s1_d;
      tms_s_q      <= tms_s_d;
      tdi_s1_q     <= tdi_s1_d;
      tdi_s_q      <= tdi_s_d;
      settle_cnt_q <= settle_cnt_d;
      state_q      <= state_d;
      ir_q         <= ir_d;
      ir_sr_q      <= ir_sr_d;
      sreg_q       <= sreg_d;
      upd_data_q   <= upd_data_d;
      upd_stb_q    <= upd_stb_d;
      cap_stb_q    <= cap_stb_d;
      tdo_q        <= tdo_d;
    end
  end

  assign tdo      = tdo_q;
  assign upd_data = upd_data_q;
  assign upd_stb  = upd_stb_q;
  assign cap_stb  = cap_stb_q;
  assign ir       = ir_q;
  assign jstate   = ~state_q;

endmodule
